// File: rtl/joypad_pkg.sv
// Shared constants for the joypad port controller: default bus addresses, the
// open-bus pattern and the width of the per-port shift counters.
package joypad_pkg;

    localparam logic [15:0] JOYPAD_BASE_ADDR = 16'h4016;
    localparam logic [7:0]  JOYPAD_OPEN_BUS  = 8'h40;
    localparam int          JOYPAD_MAX_SHIFT = 24;
    localparam int          JOYPAD_CNT_W     = $clog2(JOYPAD_MAX_SHIFT + 1);

endpackage

// File: rtl/joypad_shifter.sv
// One pad's serial shift register with a saturating shift count and exhaustion flag.
// A load wins over a shift; vacated bits fill with ones so an exhausted pad reads 1.
module joypad_shifter
    import joypad_pkg::*;
#(
    parameter int SHIFT_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [SHIFT_LEN-1:0] load_value,
    output logic                 serial_bit,
    output logic                 exhausted
);

    localparam logic [JOYPAD_CNT_W-1:0] FULL_COUNT = JOYPAD_CNT_W'(SHIFT_LEN);

    logic [SHIFT_LEN-1:0]    sr;
    logic [JOYPAD_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            count <= '0;
        end else if (load) begin
            sr    <= load_value;
            count <= '0;
        end else if (shift) begin
            sr <= {1'b1, sr[SHIFT_LEN-1:1]};
            if (count != FULL_COUNT) begin
                count <= count + JOYPAD_CNT_W'(1);
            end
        end
    end

    assign serial_bit = sr[0];
    assign exhausted  = (count == FULL_COUNT);

endmodule

// File: rtl/joypad_port_ctrl.sv
// NES-style strobe/shift controller for up to two serial pads on the CPU bus.
// Optional turbo autofire is compiled in with JOYPAD_TURBO_EN.
module joypad_port_ctrl
    import joypad_pkg::*;
#(
    parameter int          NUM_PORTS = 2,
    parameter int          SHIFT_LEN = 8,
    parameter logic [15:0] BASE_ADDR = JOYPAD_BASE_ADDR,
    parameter logic [7:0]  OPEN_BUS  = JOYPAD_OPEN_BUS,
    parameter logic [15:0] TURBO_DIV = 16'd2982
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [15:0]                    cpu_addr,
    input  logic [7:0]                     cpu_data,
    input  logic                           cpu_write_en,
    input  logic                           cpu_read_en,
    input  logic [NUM_PORTS*SHIFT_LEN-1:0] pad_input,
`ifdef JOYPAD_TURBO_EN
    input  logic [NUM_PORTS*SHIFT_LEN-1:0] turbo_mask,
`endif
    output logic [7:0]                     cpu_rdata,
    output logic                           pad_strobe,
    output logic [NUM_PORTS-1:0]           pad_exhausted
);

    logic                 write_hit;
    logic [NUM_PORTS-1:0] read_match;
    logic [NUM_PORTS-1:0] read_match_q;
    logic [NUM_PORTS-1:0] access_start;
    logic [NUM_PORTS-1:0] serial_bits;
    logic                 unused_data;

    assign write_hit   = cpu_write_en && (cpu_addr == BASE_ADDR);
    assign unused_data = ^cpu_data[7:1];

`ifdef JOYPAD_TURBO_EN
    logic [15:0] turbo_div_cnt;
    logic        turbo_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turbo_div_cnt <= '0;
            turbo_phase   <= 1'b1;
        end else if (turbo_div_cnt == TURBO_DIV - 16'd1) begin
            turbo_div_cnt <= '0;
            turbo_phase   <= ~turbo_phase;
        end else begin
            turbo_div_cnt <= turbo_div_cnt + 16'd1;
        end
    end
`endif

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [SHIFT_LEN-1:0] load_value;

`ifdef JOYPAD_TURBO_EN
        // Masked buttons only pass during the high half of the turbo period.
        assign load_value = pad_input[i*SHIFT_LEN +: SHIFT_LEN]
                          & ~(turbo_mask[i*SHIFT_LEN +: SHIFT_LEN] & ~{SHIFT_LEN{turbo_phase}});
`else
        assign load_value = pad_input[i*SHIFT_LEN +: SHIFT_LEN];
`endif

        assign read_match[i]   = cpu_read_en && (cpu_addr == BASE_ADDR + 16'(i));
        assign access_start[i] = read_match[i] && !read_match_q[i];

        // A strobe write in the same cycle as a read suppresses the shift.
        joypad_shifter #(
            .SHIFT_LEN (SHIFT_LEN)
        ) u_shifter (
            .clk        (clk),
            .rst        (rst),
            .load       (pad_strobe),
            .shift      (access_start[i] && !pad_strobe && !write_hit),
            .load_value (load_value),
            .serial_bit (serial_bits[i]),
            .exhausted  (pad_exhausted[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_strobe   <= 1'b0;
            read_match_q <= '0;
            cpu_rdata    <= {OPEN_BUS[7:1], 1'b0};
        end else begin
            read_match_q <= read_match;
            if (write_hit) begin
                pad_strobe <= cpu_data[0];
            end
            if (|access_start) begin
                cpu_rdata <= {OPEN_BUS[7:1], |(serial_bits & access_start)};
            end
        end
    end

endmodule

// File: tb/tb_joypad_port_ctrl.sv
// Self-checking bench: a two-port 8-bit controller and a one-port 24-bit controller
// share one CPU bus and are compared against a latched-value/read-index reference model.
module tb_joypad_port_ctrl;

    localparam int TD = 4;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_write_en;
    logic        cpu_read_en;
    logic [15:0] pad_a;
    logic [23:0] pad_b;
    logic [15:0] mask_a;
    logic [23:0] mask_b;
    logic [7:0]  rdata_a;
    logic [7:0]  rdata_b;
    logic        strobe_a;
    logic        strobe_b;
    logic [1:0]  exh_a;
    logic [0:0]  exh_b;

    int n_checks = 0;
    int n_fail   = 0;

    joypad_port_ctrl #(
        .NUM_PORTS (2),
        .SHIFT_LEN (8),
        .TURBO_DIV (16'(TD))
    ) dut_a (
        .clk           (clk),
        .rst           (rst),
        .cpu_addr      (cpu_addr),
        .cpu_data      (cpu_data),
        .cpu_write_en  (cpu_write_en),
        .cpu_read_en   (cpu_read_en),
        .pad_input     (pad_a),
`ifdef JOYPAD_TURBO_EN
        .turbo_mask    (mask_a),
`endif
        .cpu_rdata     (rdata_a),
        .pad_strobe    (strobe_a),
        .pad_exhausted (exh_a)
    );

    joypad_port_ctrl #(
        .NUM_PORTS (1),
        .SHIFT_LEN (24),
        .TURBO_DIV (16'(TD))
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .cpu_addr      (cpu_addr),
        .cpu_data      (cpu_data),
        .cpu_write_en  (cpu_write_en),
        .cpu_read_en   (cpu_read_en),
        .pad_input     (pad_b),
`ifdef JOYPAD_TURBO_EN
        .turbo_mask    (mask_b),
`endif
        .cpu_rdata     (rdata_b),
        .pad_strobe    (strobe_b),
        .pad_exhausted (exh_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each pad entry keeps the value latched on the last
    // strobe-high cycle and how many reads have consumed it.
    // Entries: 0 = dut_a port 0, 1 = dut_a port 1, 2 = dut_b port 0.
    logic [23:0] m_lat [3];
    int          m_reads [3];
    bit          m_prev [3];
    bit          m_strobe;
    logic [7:0]  m_rd_a;
    logic [7:0]  m_rd_b;
    int          m_edges;

    function automatic int plen(input int e);
        return (e == 2) ? 24 : 8;
    endfunction

    function automatic logic [15:0] port_addr(input int e);
        return (e == 1) ? 16'h4017 : 16'h4016;
    endfunction

    function automatic logic [23:0] get_pad(input int e);
        if (e == 0) return {16'h0, pad_a[7:0]};
        if (e == 1) return {16'h0, pad_a[15:8]};
        return pad_b;
    endfunction

    function automatic logic [23:0] get_mask(input int e);
`ifdef JOYPAD_TURBO_EN
        if (e == 0) return {16'h0, mask_a[7:0]};
        if (e == 1) return {16'h0, mask_a[15:8]};
        return mask_b;
`else
        return 24'h0 & {24{e[0]}};
`endif
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit          wr;
        bit          hit;
        bit          st;
        bit          cur;
        bit          phase;
        if (rst) begin
            for (int e = 0; e < 3; e++) begin
                m_lat[e]   = '0;
                m_reads[e] = 0;
                m_prev[e]  = 1'b0;
            end
            m_strobe = 1'b0;
            m_rd_a   = 8'h40;
            m_rd_b   = 8'h40;
            m_edges  = 0;
        end else begin
            wr    = cpu_write_en && (cpu_addr == 16'h4016);
            phase = ((m_edges / TD) % 2) == 0;
            for (int e = 0; e < 3; e++) begin
                hit       = cpu_read_en && (cpu_addr == port_addr(e));
                st        = hit && !m_prev[e];
                m_prev[e] = hit;
                cur = (m_reads[e] >= plen(e)) ? 1'b1 : m_lat[e][m_reads[e]];
                if (st) begin
                    if (e == 2) m_rd_b = {7'h20, cur};
                    else        m_rd_a = {7'h20, cur};
                    if (!m_strobe && !wr && m_reads[e] < plen(e)) m_reads[e]++;
                end
                if (m_strobe) begin
                    m_lat[e]   = get_pad(e) & ~(get_mask(e) & ~{24{phase}});
                    m_reads[e] = 0;
                end
            end
            if (wr) m_strobe = cpu_data[0];
            m_edges++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".rd_a"},  32'(rdata_a),  32'(m_rd_a));
        check({tag, ".rd_b"},  32'(rdata_b),  32'(m_rd_b));
        check({tag, ".stb_a"}, 32'(strobe_a), 32'(m_strobe));
        check({tag, ".stb_b"}, 32'(strobe_b), 32'(m_strobe));
        check({tag, ".exh_a"}, 32'(exh_a), {30'h0, m_reads[1] == 8, m_reads[0] == 8});
        check({tag, ".exh_b"}, 32'(exh_b), {31'h0, m_reads[2] == 24});
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic bus_idle();
        cpu_write_en = 1'b0;
        cpu_read_en  = 1'b0;
        cpu_addr     = 16'h0000;
    endtask

    task automatic strobe_write(input bit v);
        cpu_addr     = 16'h4016;
        cpu_data     = 8'($urandom);
        cpu_data[0]  = v;
        cpu_write_en = 1'b1;
        tick("wr");
        bus_idle();
    endtask

    task automatic read_port(input logic [15:0] addr, input int hold, input string tag);
        cpu_addr    = addr;
        cpu_read_en = 1'b1;
        repeat (hold) tick(tag);
        bus_idle();
        tick(tag);
    endtask

    logic [7:0]  seq8;
    logic [23:0] seq24;

    initial begin
        rst      = 1'b1;
        cpu_data = 8'h00;
        pad_a    = 16'h0;
        pad_b    = 24'h0;
        mask_a   = 16'h0;
        mask_b   = 24'h0;
        bus_idle();
        @(negedge clk);
        @(negedge clk);
        check("rst_rd_a", 32'(rdata_a), 32'h40);
        check("rst_rd_b", 32'(rdata_b), 32'h40);
        check("rst_stb",  32'(strobe_a), 32'h0);
        check("rst_exh",  32'({exh_b, exh_a}), 32'h0);
        rst = 1'b0;
        tick("idle");

        // Basic port 0 read
        pad_a = {8'h02, 8'h85};
        pad_b = 24'hA5_00_01;
        seq8  = 8'h85;
        strobe_write(1'b1);
        strobe_write(1'b0);
        for (int k = 0; k < 8; k++) begin
            read_port(16'h4016, 1, "p0");
            check("p0_bit", 32'(rdata_a[0]), 32'(seq8[k]));
            check("p0_hi",  32'(rdata_a[7:1]), 32'h20);
            check("p0_exh", 32'(exh_a[0]), (k == 7) ? 32'h1 : 32'h0);
        end

        // Exhaustion and port independence
        for (int k = 0; k < 3; k++) begin
            read_port(16'h4016, 1, "ex");
            check("ex_bit", 32'(rdata_a[0]), 32'h1);
        end
        read_port(16'h4017, 1, "p1");
        check("p1_bit0", 32'(rdata_a[0]), 32'h0);
        read_port(16'h4017, 1, "p1");
        check("p1_bit1", 32'(rdata_a[0]), 32'h1);
        check("p1_exh0", 32'(exh_a[0]), 32'h1);

        // Held read shifts once
        strobe_write(1'b1);
        strobe_write(1'b0);
        read_port(16'h4016, 4, "held");
        check("held_bit", 32'(rdata_a[0]), 32'h1);
        read_port(16'h4016, 1, "held");
        check("held_next", 32'(rdata_a[0]), 32'h0);

        // Strobe high: live reload, no shift
        strobe_write(1'b1);
        for (int k = 0; k < 3; k++) begin
            pad_a[0] = (k != 1);
            tick("stb");
            read_port(16'h4016, 1, "stb");
            check("stb_bit", 32'(rdata_a[0]), (k != 1) ? 32'h1 : 32'h0);
            check("stb_exh", 32'(exh_a[0]), 32'h0);
        end
        strobe_write(1'b0);

        // Reset mid-sequence
        pad_a[7:0] = 8'h85;
        strobe_write(1'b1);
        strobe_write(1'b0);
        for (int k = 0; k < 3; k++) read_port(16'h4016, 1, "pre");
        rst = 1'b1;
        #1;
        check("mid_rst_rd",  32'(rdata_a), 32'h40);
        check("mid_rst_exh", 32'({exh_b, exh_a}), 32'h0);
        @(negedge clk);
        compare_all("mid_rst");
        rst = 1'b0;
        read_port(16'h4016, 1, "post");
        check("post_bit", 32'(rdata_a[0]), 32'h0);

        // 24-bit pad
        seq24 = 24'hA5_00_01;
        pad_b = seq24;
        strobe_write(1'b1);
        strobe_write(1'b0);
        for (int k = 0; k < 27; k++) begin
            read_port(16'h4016, 1, "len24");
            check("len24_bit", 32'(rdata_b[0]), (k < 24) ? 32'(seq24[k]) : 32'h1);
        end
        check("len24_exh", 32'(exh_b), 32'h1);

        // Turbo: A held, masked
        pad_a  = 16'h0001;
        mask_a = 16'h0001;
        strobe_write(1'b1);
        for (int k = 0; k < 12; k++) begin
            read_port(16'h4016, 1, "turbo");
`ifndef JOYPAD_TURBO_EN
            check("turbo_const", 32'(rdata_a[0]), 32'h1);
`endif
        end
        strobe_write(1'b0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int sel;
            pad_a  = 16'($urandom);
            pad_b  = 24'($urandom);
            mask_a = 16'($urandom);
            mask_b = 24'($urandom);
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1, 2: cpu_addr = 16'h4016;
                3, 4:    cpu_addr = 16'h4017;
                default: cpu_addr = ($urandom_range(0, 1) == 0) ? 16'h4015 : 16'h4018;
            endcase
            cpu_read_en  = ($urandom_range(0, 2) != 0);
            cpu_write_en = ($urandom_range(0, 11) == 0);
            cpu_data     = 8'($urandom);
            cpu_data[0]  = ($urandom_range(0, 3) == 0);
            tick("rnd");
        end
        bus_idle();
        tick("end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/joypad_port_ctrl.md
# joypad_port_ctrl

Parametrised controller-port block that emulates the NES joypad strobe/shift protocol for up to two serial pads. It sits on the CPU bus decode next to the other memory-mapped I/O and presents a registered read value to the CPU data mux. Compared with the single-port 8-bit version, it adds:

- per-port shift registers of configurable length;
- true strobe-level semantics, with continuous reload while strobe is high;
- exactly one shift per read access, regardless of how long `cpu_read_en` is held;
- fill-with-ones after exhaustion and open-bus upper bits;
- optional turbo autofire.

## Interface
Parameters:
- `NUM_PORTS`, default 2: number of pads, legal range 1..2. Port i is read at `BASE_ADDR+i`.
- `SHIFT_LEN`, default 8: serial bits per pad, legal range 8..24.
- `BASE_ADDR`, default 16'h4016: strobe write address and port 0 read address.
- `OPEN_BUS`, default 8'h40: supplies bits [7:1] of every read value.
- `TURBO_DIV`, default 16'd2982: clock cycles per turbo half-period. Only used with the turbo macro.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `cpu_addr` in 16: CPU address.
- `cpu_data` in 8: CPU write data. Only bit 0 is used.
- `cpu_write_en` in 1: CPU write strobe.
- `cpu_read_en` in 1: CPU read strobe. May stay high for several cycles.
- `pad_input` in NUM_PORTS*SHIFT_LEN: live button states, 1 = pressed. Port i occupies slice [i*SHIFT_LEN +: SHIFT_LEN], bit 0 = A.
- `turbo_mask` in NUM_PORTS*SHIFT_LEN: per-button turbo enable. Present only with `JOYPAD_TURBO_EN`.
- `cpu_rdata` out 8: registered read value.
- `pad_strobe` out 1: current strobe latch state.
- `pad_exhausted` out NUM_PORTS: bit i is high once port i has shifted SHIFT_LEN times since its last load.

## Operation
- **Strobe write.** A cycle with `cpu_write_en` high and `cpu_addr==BASE_ADDR` sets `pad_strobe <= cpu_data[0]`. This single write affects all ports.
- **Strobe high.**
  - Every cycle, each port's shift register reloads from its `pad_input` slice (after turbo gating) and its shift count clears to 0.
  - Reads return the current bit 0 and do not shift.
- **Strobe falling.** The value loaded on the last strobe-high cycle is held.
- **Read access.**
  - An access starts on the first cycle where `cpu_read_en` is high and `cpu_addr==BASE_ADDR+i`, and the previous cycle was not an access to the same address. This is rising-edge detection on the qualified match.
  - On that cycle: `cpu_rdata <= {OPEN_BUS[7:1], sr_i[0]}`.
  - If strobe is low, the register also shifts: `sr_i <= {1'b1, sr_i[SHIFT_LEN-1:1]}` and the count increments, saturating at SHIFT_LEN.
- **Exhaustion.** `pad_exhausted[i] = (count_i == SHIFT_LEN)`. After SHIFT_LEN shifts, reads return bit 1 indefinitely.
- **Non-access cycles.** `cpu_rdata` holds its last value.
- **Write and read in the same cycle.** This can only occur if the address decoder allows it. The write takes effect and no shift occurs; `cpu_rdata` still updates from the pre-write register.
- **Addresses outside the port window.** These have no effect. Ports with i ≥ NUM_PORTS do not decode.

## Timing
- Reset values: `cpu_rdata = {OPEN_BUS[7:1],1'b0}`, `pad_strobe = 0`, all shift registers = 0, counts = 0, so `pad_exhausted = 0`. Turbo divider = 0, turbo phase = 1.
- `cpu_rdata` latency: valid on the clock edge ending the first cycle of the access. It is readable the cycle after `cpu_read_en` rises.
- A strobe write is visible on `pad_strobe` one cycle later. The reload begins in the cycle after the write.
- A reset asserted mid-access or mid-shift aborts immediately. The next read after reset returns 0 in bit 0 until a strobe reload occurs.

## Configuration
- With `JOYPAD_TURBO_EN` defined:
  - A free-running divider counts 0..TURBO_DIV-1 and toggles `turbo_phase` on wrap.
  - The loaded value per bit is `pad_input & ~(turbo_mask & ~{SHIFT_LEN{turbo_phase}})`, i.e. masked buttons pass only while phase = 1.
- Without the macro: the `turbo_mask` port, the divider and the phase are absent, and loads take `pad_input` directly.

## Structure
- Package `joypad_pkg` holds:
  - defaults `JOYPAD_BASE_ADDR` (16'h4016), `JOYPAD_OPEN_BUS` (8'h40) and `JOYPAD_MAX_SHIFT` (24);
  - the count-width constant `$clog2(JOYPAD_MAX_SHIFT+1)`.
- Sub-module `joypad_shifter`, one instance per port, generated. It contains the shift register, the saturating count and the exhaustion flag. Its inputs are `load`, `shift` and `load_value`.
- The top level contains the strobe latch, address decode, read-edge detector, turbo divider and `cpu_rdata` mux.

## Test plan
1. **Basic port 0 read.** `pad_input` port0 = 8'b1000_0101. Write 1 then 0 to 4016, then do 8 single-cycle reads of 4016. Required: `cpu_rdata[0]` sequence 1,0,1,0,0,0,0,1, each with `cpu_rdata[7:1]=7'h20`. `pad_exhausted[0]` rises after the 8th read.
2. **Exhaustion and port independence.** Perform 3 further reads of 4016. Required: bit 0 = 1 each time. Then read 4017 with port1 = 8'h02. Required: 0 then 1, unaffected by port 0.
3. **Held read.** Hold `cpu_read_en` high for 4 cycles on 4016. Required: exactly one shift; the count increments by 1.
4. **Strobe high.** Strobe = 1, read 4016 three times while toggling `pad_input[0]` 1→0→1. Required: returns 1,0,1 with no shift and count 0.
5. **Reset and length.** Assert reset mid-sequence after 3 reads. Required: `cpu_rdata=8'h40` and `pad_exhausted=0` during reset. Then, with SHIFT_LEN=24, run the sequence with port0 = 24'hA5_00_01. Required: 24 correct bits followed by 1s.
6. **Turbo.** With `JOYPAD_TURBO_EN`, TURBO_DIV=4, mask bit 0 set, A held pressed. Required: values latched on successive reloads alternate 1/0 every 4 cycles. Without the macro, the same stimulus latches a constant 1.
